am_lock_fsm: RTL and testbench

Per-lane alignment-marker lock state machine for the 100GbE PCS receive path. It sits directly downstream of the AM comparator and closes the loop with it. Each cycle it drives the comparator's enable mask, timer-done flag and expected-AM mask, and it consumes the comparator's match flag and one-hot match vector. From these it acquires and holds AM lock, reports the PCS lane ID, and emits a per-AM strobe for the deskew stage.

---
 rtl/am_lock_fsm_pkg.sv | 43 ++++
 rtl/am_lock_fsm_period_timer.sv | 42 ++++
 rtl/am_lock_fsm.sv | 177 +++++++++++++++++
 tb/tb_am_lock_fsm.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_lock_fsm_pkg.sv
// ============================================================================
// Module   : am_lock_fsm_pkg
// Purpose  : Shared definitions for the per-lane alignment-marker lock logic:
//            state encodings, default AM period / miss limit, and the lane-ID
//            priority encoder (also used by the deskew stage).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package am_lock_fsm_pkg;

    localparam int C_N_ALIGNER   = 20;
    localparam int C_NB_LANE_ID  = 5;
    localparam int C_N_BLOCKS    = 16384;
    localparam int C_NB_COUNTER  = 14;
    localparam int C_MAX_INVALID = 4;
    localparam int C_NB_INV      = 3;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_WAIT_1ST = 2'd1,
        ST_WAIT_2ND = 2'd2,
        ST_LOCKED   = 2'd3
    } am_state_t;

    // Index of the lowest set bit; a multi-hot vector resolves to the lowest
    // lane, an all-zero vector encodes as lane 0.
    function automatic logic [C_NB_LANE_ID-1:0] am_lane_encode(
        input logic [C_N_ALIGNER-1:0] vec
    );
        logic [C_NB_LANE_ID-1:0] idx;
        idx = '0;
        for (int i = C_N_ALIGNER - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = C_NB_LANE_ID'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/am_lock_fsm_period_timer.sv
// ============================================================================
// Module   : am_period_timer
// Purpose  : Valid-block counter marking the expected AM position. Counts
//            0..N_BLOCKS-1 on each enabled block and wraps to 0 on the block
//            where o_done is high, so it never exceeds N_BLOCKS-1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module am_period_timer #(
    parameter int N_BLOCKS   = 16384,
    parameter int NB_COUNTER = 14
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);

    localparam logic [NB_COUNTER-1:0] C_LAST = NB_COUNTER'(N_BLOCKS - 1);

    logic [NB_COUNTER-1:0] r_count;

    // Done is decoded purely from the register so the comparator loop stays
    // free of combinational paths.
    assign o_done = (r_count == C_LAST);

    // Block counter: clear has priority, then count with wrap at the AM slot.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_done ? '0 : r_count + NB_COUNTER'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/am_lock_fsm.sv
// ============================================================================
// Module   : am_lock_fsm
// Purpose  : Per-lane alignment-marker lock FSM for the 100GbE PCS receive
//            path. Drives the AM comparator masks/timer flag, acquires and
//            holds AM lock, reports lane ID and emits per-AM strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module am_lock_fsm
    import am_lock_fsm_pkg::*;
#(
    parameter int N_ALIGNER   = C_N_ALIGNER,
    parameter int NB_LANE_ID  = C_NB_LANE_ID,
    parameter int N_BLOCKS    = C_N_BLOCKS,
    parameter int NB_COUNTER  = C_NB_COUNTER,
    parameter int MAX_INVALID = C_MAX_INVALID,
    parameter int NB_INV      = C_NB_INV
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_block_lock,
    input  logic                  i_am_match,
    input  logic [N_ALIGNER-1:0]  i_match_vector,
    output logic                  o_enable_mask,
    output logic                  o_timer_done,
    output logic [N_ALIGNER-1:0]  o_match_mask,
    output logic                  o_am_lock,
    output logic [NB_LANE_ID-1:0] o_lane_id,
    output logic                  o_am_strobe,
    output logic                  o_lock_lost
);

    // Invalid count value at which one more miss drops lock.
    localparam logic [NB_INV-1:0] C_LAST_MISS = NB_INV'(MAX_INVALID - 1);

    am_state_t             r_state;
    logic [N_ALIGNER-1:0]  r_expected;
    logic [NB_LANE_ID-1:0] r_lane_id;
    logic [NB_INV-1:0]     r_invalid;
    logic                  r_strobe;
    logic                  r_lost;

    am_state_t             w_state_next;
    logic [N_ALIGNER-1:0]  w_expected_next;
    logic [NB_LANE_ID-1:0] w_lane_id_next;
    logic [NB_INV-1:0]     w_invalid_next;
    logic                  w_strobe_next;
    logic                  w_lost_next;
    logic                  w_enable_mask;
    logic [N_ALIGNER-1:0]  w_match_mask;
    logic                  w_tracking;
    logic                  w_first_am;
    logic                  w_period_end;
    logic [N_ALIGNER-1:0]  w_lowest_hit;
    logic [NB_LANE_ID-1:0] w_hit_lane;

    // Isolate the lowest set bit (two's-complement trick) and encode it.
    assign w_lowest_hit = i_match_vector & (~i_match_vector + N_ALIGNER'(1));
    assign w_hit_lane   = NB_LANE_ID'(am_lane_encode(C_N_ALIGNER'(i_match_vector)));

    assign w_first_am   = (r_state == ST_WAIT_1ST) && i_valid && i_am_match;

    am_period_timer #(
        .N_BLOCKS   (N_BLOCKS),
        .NB_COUNTER (NB_COUNTER)
    ) u_timer (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (!i_block_lock || w_first_am),
        .i_enable (i_valid && w_tracking),
        .o_done   (w_period_end)
    );

    // State and registered decision outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_INIT;
            r_expected <= '0;
            r_lane_id  <= '0;
            r_invalid  <= '0;
            r_strobe   <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_expected <= w_expected_next;
            r_lane_id  <= w_lane_id_next;
            r_invalid  <= w_invalid_next;
            r_strobe   <= w_strobe_next;
            r_lost     <= w_lost_next;
        end
    end

    // Next-state and comparator-facing outputs; block-lock loss overrides all.
    always_comb begin
        w_state_next    = r_state;
        w_expected_next = r_expected;
        w_lane_id_next  = r_lane_id;
        w_invalid_next  = r_invalid;
        w_strobe_next   = 1'b0;
        w_lost_next     = 1'b0;
        w_enable_mask   = 1'b0;
        w_match_mask    = '0;
        w_tracking      = 1'b0;

        case (r_state)
            ST_INIT: begin
                if (i_valid) begin
                    w_state_next = ST_WAIT_1ST;
                end
            end

            ST_WAIT_1ST: begin
                w_enable_mask = 1'b1;
                w_match_mask  = '1;
                if (i_valid && i_am_match) begin
                    w_expected_next = w_lowest_hit;
                    w_lane_id_next  = w_hit_lane;
                    w_state_next    = ST_WAIT_2ND;
                end
            end

            ST_WAIT_2ND: begin
                w_match_mask = r_expected;
                w_tracking   = 1'b1;
                if (i_valid && w_period_end) begin
                    if (i_am_match) begin
                        w_state_next   = ST_LOCKED;
                        w_invalid_next = '0;
                    end else begin
                        w_state_next = ST_WAIT_1ST;
                    end
                end
            end

            ST_LOCKED: begin
                w_match_mask = r_expected;
                w_tracking   = 1'b1;
                if (i_valid && w_period_end) begin
                    if (i_am_match) begin
                        w_invalid_next = '0;
                        w_strobe_next  = 1'b1;
                    end else if (r_invalid == C_LAST_MISS) begin
                        w_invalid_next = '0;
                        w_lost_next    = 1'b1;
                        w_state_next   = ST_WAIT_1ST;
                    end else begin
                        w_invalid_next = r_invalid + NB_INV'(1);
                    end
                end
            end

            default: begin
                w_state_next = ST_INIT;
            end
        endcase

        if (!i_block_lock) begin
            w_state_next   = ST_INIT;
            w_invalid_next = '0;
            w_strobe_next  = 1'b0;
            w_lost_next    = 1'b0;
        end
    end

    assign o_enable_mask = w_enable_mask;
    assign o_match_mask  = w_match_mask;
    assign o_timer_done  = w_period_end && w_tracking;
    assign o_am_lock     = (r_state == ST_LOCKED);
    assign o_lane_id     = r_lane_id;
    assign o_am_strobe   = r_strobe;
    assign o_lock_lost   = r_lost;

endmodule

`default_nettype wire

// File: tb/tb_am_lock_fsm.sv
// ============================================================================
// Module   : tb_am_lock_fsm
// Purpose  : Self-checking bench for am_lock_fsm with a short AM period.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_am_lock_fsm;

    localparam int NA   = 20;
    localparam int NBL  = 16;
    localparam int MAXI = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          valid    = 1'b0;
    logic          blk      = 1'b0;
    logic          am_match = 1'b0;
    logic [NA-1:0] vec      = '0;

    logic          enable_mask;
    logic          timer_done;
    logic [NA-1:0] match_mask;
    logic          am_lock;
    logic [4:0]    lane_id;
    logic          am_strobe;
    logic          lock_lost;

    always #5 clk = ~clk;

    am_lock_fsm #(
        .N_ALIGNER   (NA),
        .NB_LANE_ID  (5),
        .N_BLOCKS    (NBL),
        .NB_COUNTER  (4),
        .MAX_INVALID (MAXI),
        .NB_INV      (3)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_valid        (valid),
        .i_block_lock   (blk),
        .i_am_match     (am_match),
        .i_match_vector (vec),
        .o_enable_mask  (enable_mask),
        .o_timer_done   (timer_done),
        .o_match_mask   (match_mask),
        .o_am_lock      (am_lock),
        .o_lane_id      (lane_id),
        .o_am_strobe    (am_strobe),
        .o_lock_lost    (lock_lost)
    );

    int n_checks  = 0;
    int n_pass    = 0;
    int lost_seen = 0;
    bit chk_en    = 1'b0;

    // Reference model: phase 0 = no block lock, 1 = hunting, 2 = confirming,
    // 3 = locked. m_pos is the position of the next block relative to the
    // last anchoring AM (anchor = position 0); the next AM is due at NBL.
    int            m_phase = 0;
    int            m_pos   = 0;
    int            m_miss  = 0;
    int            m_lane  = 0;
    logic [NA-1:0] m_exp   = '0;
    bit            m_strobe = 1'b0;
    bit            m_lost   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        int lo;
        m_strobe = 1'b0;
        m_lost   = 1'b0;
        if (!blk) begin
            m_phase = 0;
            m_miss  = 0;
        end else if (valid) begin
            if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (am_match) begin
                    lo = 0;
                    for (int i = 0; i < NA; i++) begin
                        if (vec[i]) begin
                            lo = i;
                            break;
                        end
                    end
                    m_lane  = lo;
                    m_exp   = (vec == '0) ? '0 : (NA'(1) << lo);
                    m_pos   = 1;
                    m_phase = 2;
                end
            end else if (m_pos != NBL) begin
                m_pos++;
            end else begin
                m_pos = 1;
                if (m_phase == 2) begin
                    m_phase = am_match ? 3 : 1;
                    m_miss  = 0;
                end else if (am_match) begin
                    m_miss   = 0;
                    m_strobe = 1'b1;
                end else begin
                    m_miss++;
                    if (m_miss == MAXI) begin
                        m_lost  = 1'b1;
                        m_phase = 1;
                        m_miss  = 0;
                    end
                end
            end
        end
    endtask

    // Advance the model on every clock edge; reset it with the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_pos = 0; m_miss = 0; m_lane = 0;
            m_exp = '0; m_strobe = 1'b0; m_lost = 1'b0;
        end else begin
            model_step();
        end
    end

    // Compare every DUT output with the model mid-cycle.
    always @(negedge clk) begin
        logic [NA-1:0] exp_mask;
        #1;
        if (chk_en && rst_n) begin
            exp_mask = (m_phase == 0) ? '0 : (m_phase == 1) ? '1 : m_exp;
            chk("enable_mask", 32'(enable_mask), 32'(m_phase == 1));
            chk("match_mask",  32'(match_mask),  32'(exp_mask));
            chk("timer_done",  32'(timer_done),  32'(m_phase >= 2 && m_pos == NBL));
            chk("am_lock",     32'(am_lock),     32'(m_phase == 3));
            chk("lane_id",     32'(lane_id),     32'(m_lane));
            chk("am_strobe",   32'(am_strobe),   32'(m_strobe));
            chk("lock_lost",   32'(lock_lost),   32'(m_lost));
            if (lock_lost) lost_seen++;
        end
    end

    task automatic drive(input logic v, input logic b, input logic m, input logic [NA-1:0] vv);
        @(negedge clk);
        valid    = v;
        blk      = b;
        am_match = m;
        vec      = vv;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic am(input int lane);
        logic [NA-1:0] t;
        t       = '0;
        t[lane] = 1'b1;
        drive(1'b1, 1'b1, 1'b1, t);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset held with lane active: everything must stay zero.
        blk = 1'b1; valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_enable",  32'(enable_mask), 0);
        chk("rst_mask",    32'(match_mask),  0);
        chk("rst_timer",   32'(timer_done),  0);
        chk("rst_lock",    32'(am_lock),     0);
        chk("rst_lane",    32'(lane_id),     0);
        chk("rst_strobe",  32'(am_strobe),   0);
        chk("rst_lost",    32'(lock_lost),   0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Lock on lane 7: AM at block 0 and block 16.
        am(7); idle(NBL - 1); am(7);
        settle();
        chk("s1_lock", 32'(am_lock),    1);
        chk("s1_lane", 32'(lane_id),    7);
        chk("s1_mask", 32'(match_mask), 32'h80);

        // One more good period yields a strobe.
        idle(NBL - 1); am(7);
        settle();
        chk("s1_strobe", 32'(am_strobe), 1);

        // Valid gap of 5 inside the period; AM still at 16th valid block.
        idle(5);
        repeat (5) drive(1'b0, 1'b1, 1'b0, '0);
        idle(NBL - 6);
        am(7);
        #1;
        chk("gap_timer_done", 32'(timer_done), 1);
        settle();
        chk("gap_strobe", 32'(am_strobe), 1);

        // Block lock drops while locked.
        drive(1'b1, 1'b0, 1'b0, '0);
        settle();
        chk("bl_lock", 32'(am_lock),   0);
        chk("bl_lost", 32'(lock_lost), 0);
        chk("bl_mask", 32'(match_mask), 0);
        drive(1'b1, 1'b1, 1'b0, '0);

        // Second position carries a different lane: slip back to hunting.
        am(3); idle(NBL - 1);
        drive(1'b1, 1'b1, 1'b0, NA'(1) << 5);
        settle();
        chk("slip_lock",   32'(am_lock),     0);
        chk("slip_mask",   32'(match_mask),  32'hFFFFF);
        chk("slip_enable", 32'(enable_mask), 1);

        // Lock on lane 0, then four consecutive misses.
        am(0); idle(NBL - 1); am(0);
        settle();
        chk("l0_lock", 32'(am_lock), 1);
        chk("l0_lane", 32'(lane_id), 0);
        for (int k = 1; k <= MAXI; k++) begin
            idle(NBL - 1);
            drive(1'b1, 1'b1, 1'b0, '0);
            settle();
            chk("miss_lost", 32'(lock_lost), 32'(k == MAXI));
            chk("miss_lock", 32'(am_lock),   32'(k != MAXI));
        end
        idle(1);
        #2;
        chk("lost_once", 32'(lost_seen), 1);

        // Relock; three misses then a hit resets the miss count.
        am(0); idle(NBL - 1); am(0);
        repeat (3) begin
            idle(NBL - 1);
            drive(1'b1, 1'b1, 1'b0, '0);
        end
        idle(NBL - 1); am(0);
        idle(NBL - 1);
        drive(1'b1, 1'b1, 1'b0, '0);
        settle();
        chk("hold_lock", 32'(am_lock), 1);
        chk("hold_lost_count", 32'(lost_seen), 1);

        // Multi-hot first AM resolves to the lowest lane.
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, 20'h00050);
        settle();
        chk("mh_lane", 32'(lane_id),    4);
        chk("mh_mask", 32'(match_mask), 32'h10);

        // Asynchronous reset in the middle of confirming.
        idle(3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_mask",   32'(match_mask),  0);
        chk("arst_lane",   32'(lane_id),     0);
        chk("arst_enable", 32'(enable_mask), 0);
        chk("arst_lock",   32'(am_lock),     0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
